// File: rtl/ip_arb_pkg.sv
// Shared types and constants for the IP transmit arbiter slice.
// Holds the arbiter state encoding, the IP header layout and the round-robin step helper.
package ip_arb_pkg;

  localparam int unsigned IP_HDR_W = 160;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [15:0] identification;
    logic [2:0]  flags;
    logic [12:0] fragment_offset;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] header_checksum;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } ip_hdr_t;

  // Next requester index in circular order, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from the requester after the last
// winner, wrapping, and returns the first active request as one-hot and index.
module rr_arbiter
  import ip_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = rr_next(32'(last), N);
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[cand[IW-1:0]]) begin
        found                   = 1'b1;
        idx                     = cand[IW-1:0];
        grant[cand[IW-1:0]]     = 1'b1;
      end
      cand = rr_next(cand, N);
    end
  end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Frame-level arbiter merging N_REQ IP header+payload streams onto one output.
// A winner owns the header channel, then the payload channel until tlast.
module ip_tx_arbiter
  import ip_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned HDR_W = IP_HDR_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        s_hdr_valid,
  output logic [N_REQ-1:0]        s_hdr_ready,
  input  logic [N_REQ*HDR_W-1:0]  s_hdr_data,
  input  logic [N_REQ*DW-1:0]     s_tdata,
  input  logic [N_REQ-1:0]        s_tvalid,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic [N_REQ-1:0]        s_tready,
  output logic                    m_hdr_valid,
  input  logic                    m_hdr_ready,
  output logic [HDR_W-1:0]        m_hdr_data,
  output logic [DW-1:0]           m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy
);

  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    last_winner;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] rr_grant;
  logic [IW-1:0]    rr_idx;
  logic             rr_found;
  logic             arb_armed;
  logic             hdr_fire;
  logic             tail_fire;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req   (s_hdr_valid),
    .last  (last_winner),
    .grant (rr_grant),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Arbitration is held off for one edge after reset release, so the
  // earliest grant lands on the second rising edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      arb_armed <= 1'b0;
    end else begin
      arb_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      gidx        <= '0;
      grant_q     <= '0;
      last_winner <= IW'(N_REQ - 1);
    end else if (state == IDLE && state_nxt == HDR) begin
      gidx    <= rr_idx;
      grant_q <= rr_grant;
    end else if (state == PAYLOAD && state_nxt == IDLE) begin
      last_winner <= gidx;
      grant_q     <= '0;
    end
  end

  always_comb begin
    hdr_fire  = m_hdr_valid & m_hdr_ready;
    tail_fire = m_tvalid & m_tready & m_tlast;
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_armed && rr_found) state_nxt = HDR;
      HDR:     if (hdr_fire)              state_nxt = PAYLOAD;
      PAYLOAD: if (tail_fire)             state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Every mux is steered by the registered owner index; requests never reach it.
  always_comb begin
    s_hdr_ready = '0;
    s_tready    = '0;
    m_hdr_valid = 1'b0;
    m_hdr_data  = '0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    unique case (state)
      HDR: begin
        m_hdr_valid       = s_hdr_valid[gidx];
        s_hdr_ready[gidx] = m_hdr_ready;
        for (int unsigned k = 0; k < N_REQ; k++) begin
          if (gidx == IW'(k)) m_hdr_data = s_hdr_data[k*HDR_W +: HDR_W];
        end
      end
      PAYLOAD: begin
        m_tvalid       = s_tvalid[gidx];
        m_tlast        = s_tlast[gidx];
        s_tready[gidx] = m_tready;
        for (int unsigned k = 0; k < N_REQ; k++) begin
          if (gidx == IW'(k)) m_tdata = s_tdata[k*DW +: DW];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_grant = grant_q;
    o_busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: per-cycle vector table for a full frame
// sequence, then hand-written round-robin, backpressure, stall and reset sequences.
module tb_ip_tx_arbiter;
  import ip_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int HW = 160;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [N-1:0]      s_hdr_valid = '0;
  logic [N-1:0]      s_hdr_ready;
  logic [N*HW-1:0]   s_hdr_data = '0;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N-1:0]      s_tready;
  logic              m_hdr_valid;
  logic              m_hdr_ready = 1'b0;
  logic [HW-1:0]     m_hdr_data;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b0;
  logic [N-1:0]      o_grant;
  logic              o_busy;

  ip_tx_arbiter #(.N_REQ(N), .DW(DW), .HDR_W(HW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .s_hdr_valid (s_hdr_valid),
    .s_hdr_ready (s_hdr_ready),
    .s_hdr_data  (s_hdr_data),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_hdr_valid (m_hdr_valid),
    .m_hdr_ready (m_hdr_ready),
    .m_hdr_data  (m_hdr_data),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] hdr_pat(input int k);
    logic [31:0] w;
    w = 32'hC0A8_0100 + 32'(k);
    return {w, ~w, w ^ 32'h5A5A_5A5A, w, 32'(k) * 32'h0101_0101};
  endfunction

  function automatic logic [DW-1:0] lane_pat(input int k);
    return 8'hA0 + 8'(k);
  endfunction

  function automatic int oh2i(input logic [N-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic zero_inputs();
    s_hdr_valid = '0;
    s_tvalid    = '0;
    s_tlast     = '0;
    m_hdr_ready = 1'b0;
    m_tready    = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    i_rst = 1'b1;
    #1;
    chk("rst_busy", HW'(o_busy), '0);
    chk("rst_grant", HW'(o_grant), '0);
    chk("rst_mvalids", HW'({m_hdr_valid, m_tvalid}), '0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
  endtask

  typedef struct {
    logic [N-1:0] hv, tv, tl;
    logic         mhr, mtr;
    logic [N-1:0] e_grant;
    logic         e_busy, e_mhv, e_mtv, e_mtl;
    logic [N-1:0] e_shr, e_str;
  } vec_t;

  vec_t         tbl[12];
  logic [DW-1:0] bytes[6];
  logic [DW-1:0] rx[$];
  int            idx;

  initial begin
    // hv tv tl mhr mtr | grant busy mhv mtv mtl shr str
    tbl[0]  = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000};
    tbl[3]  = '{4'b1000, 4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010};
    tbl[4]  = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010};
    tbl[5]  = '{4'b1000, 4'b0010, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1001, 4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010};
    tbl[7]  = '{4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b1000, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};

    for (int k = 0; k < N; k++) begin
      s_hdr_data[k*HW +: HW] = hdr_pat(k);
      s_tdata[k*DW +: DW]    = lane_pat(k);
    end

    // Vector table: one row per clock cycle, inputs applied after the edge.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      @(posedge i_clk);
      #1;
      s_hdr_valid = tbl[r].hv;
      s_tvalid    = tbl[r].tv;
      s_tlast     = tbl[r].tl;
      m_hdr_ready = tbl[r].mhr;
      m_tready    = tbl[r].mtr;
      @(negedge i_clk);
      chk($sformatf("row%0d_grant", r), HW'(o_grant), HW'(tbl[r].e_grant));
      chk($sformatf("row%0d_busy", r), HW'(o_busy), HW'(tbl[r].e_busy));
      chk($sformatf("row%0d_m_hdr_valid", r), HW'(m_hdr_valid), HW'(tbl[r].e_mhv));
      chk($sformatf("row%0d_m_tvalid", r), HW'(m_tvalid), HW'(tbl[r].e_mtv));
      chk($sformatf("row%0d_m_tlast", r), HW'(m_tlast), HW'(tbl[r].e_mtl));
      chk($sformatf("row%0d_s_hdr_ready", r), HW'(s_hdr_ready), HW'(tbl[r].e_shr));
      chk($sformatf("row%0d_s_tready", r), HW'(s_tready), HW'(tbl[r].e_str));
      if (tbl[r].e_mhv)
        chk($sformatf("row%0d_m_hdr_data", r), m_hdr_data, hdr_pat(oh2i(tbl[r].e_grant)));
      if (tbl[r].e_mtv)
        chk($sformatf("row%0d_m_tdata", r), HW'(m_tdata), HW'(lane_pat(oh2i(tbl[r].e_grant))));
    end

    // Asynchronous reset while a header is pending, then first-grant latency.
    #1;
    i_rst = 1'b1;
    s_hdr_valid = 4'b0101;
    #1;
    chk("async_rst_grant", HW'(o_grant), '0);
    chk("async_rst_busy", HW'(o_busy), '0);
    chk("async_rst_m_hdr_valid", HW'(m_hdr_valid), '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("first_edge_no_grant", HW'(o_grant), '0);
    @(negedge i_clk);
    chk("second_edge_grant0", HW'(o_grant), HW'(4'b0001));

    // Round-robin: all four request continuously, 12 two-beat frames.
    do_reset();
    for (int f = 0; f < 12; f++) begin
      @(posedge i_clk);
      #1;
      s_hdr_valid = 4'b1111;
      s_tvalid    = 4'b1111;
      s_tlast     = 4'b0000;
      m_hdr_ready = 1'b1;
      m_tready    = 1'b1;
      @(negedge i_clk);
      chk($sformatf("rr%0d_idle_busy", f), HW'(o_busy), '0);
      chk($sformatf("rr%0d_idle_grant", f), HW'(o_grant), '0);
      @(negedge i_clk);
      chk($sformatf("rr%0d_grant", f), HW'(o_grant), HW'(4'b0001 << (f % 4)));
      chk($sformatf("rr%0d_hdr", f), m_hdr_data, hdr_pat(f % 4));
      @(negedge i_clk);
      chk($sformatf("rr%0d_beat0", f), HW'({m_tvalid, m_tlast, m_tdata}), HW'({2'b10, lane_pat(f % 4)}));
      @(posedge i_clk);
      #1;
      s_tlast = 4'b1111;
      @(negedge i_clk);
      chk($sformatf("rr%0d_beat1", f), HW'({m_tvalid, m_tlast, m_tdata}), HW'({2'b11, lane_pat(f % 4)}));
    end

    // Requester 2 frame with m_tready toggling every cycle.
    do_reset();
    for (int i = 0; i < 6; i++) bytes[i] = 8'h51 + 8'(i);
    @(posedge i_clk);
    #1;
    s_hdr_valid = 4'b0100;
    m_hdr_ready = 1'b1;
    m_tready    = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("bp_grant", HW'(o_grant), HW'(4'b0100));
    idx = 0;
    rx.delete();
    for (int c = 0; c < 40 && idx < 6; c++) begin
      @(posedge i_clk);
      #1;
      s_hdr_valid       = '0;
      s_tvalid          = 4'b0100;
      s_tdata[2*DW +: DW] = bytes[idx];
      s_tlast           = (idx == 5) ? 4'b0100 : 4'b0000;
      m_tready          = (c % 2 == 0);
      @(negedge i_clk);
      chk($sformatf("bp_s_tready_c%0d", c), HW'(s_tready), HW'({1'b0, m_tready, 2'b00}));
      if (m_tvalid && m_tready) begin
        rx.push_back(m_tdata);
        idx++;
      end
    end
    chk("bp_rx_count", HW'(rx.size()), HW'(6));
    for (int i = 0; i < 6; i++)
      if (i < rx.size()) chk($sformatf("bp_byte%0d", i), HW'(rx[i]), HW'(bytes[i]));
    @(posedge i_clk);
    #1;
    s_tvalid = '0;
    s_tlast  = '0;
    @(negedge i_clk);
    chk("bp_idle_after", HW'(o_busy), '0);

    // No preemption, 10-cycle owner stall, then mid-payload reset.
    do_reset();
    m_hdr_ready = 1'b1;
    m_tready    = 1'b1;
    s_hdr_valid = 4'b0001;
    s_tdata[0 +: DW] = 8'h70;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("np_grant0", HW'(o_grant), HW'(4'b0001));
    @(posedge i_clk);
    #1;
    s_hdr_valid = 4'b1000;
    s_tvalid    = 4'b0001;
    s_tdata[0 +: DW] = 8'h71;
    @(negedge i_clk);
    chk("np_beat0", HW'({m_tvalid, m_tlast, m_tdata}), HW'({2'b10, 8'h71}));
    chk("np_no_hdr", HW'({m_hdr_valid, s_hdr_ready}), '0);
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clk);
      #1;
      s_tvalid = '0;
      @(negedge i_clk);
      chk($sformatf("stall%0d", c), HW'({o_grant, m_tvalid, m_hdr_valid}), HW'({4'b0001, 2'b00}));
    end
    @(posedge i_clk);
    #1;
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0001;
    s_tdata[0 +: DW] = 8'h72;
    @(negedge i_clk);
    chk("np_beat1", HW'({m_tvalid, m_tlast, m_tdata}), HW'({2'b11, 8'h72}));
    @(posedge i_clk);
    #1;
    s_tvalid = '0;
    s_tlast  = '0;
    @(negedge i_clk);
    chk("np_gap", HW'({o_busy, o_grant}), '0);
    @(negedge i_clk);
    chk("np_grant3", HW'(o_grant), HW'(4'b1000));
    chk("np_hdr3", m_hdr_data, hdr_pat(3));
    @(posedge i_clk);
    #1;
    s_hdr_valid = 4'b0101;
    s_tvalid    = 4'b1000;
    @(negedge i_clk);
    chk("mid_payload_tvalid", HW'({m_tvalid, m_tdata}), HW'({1'b1, lane_pat(3)}));
    #1;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ctl", HW'({o_grant, o_busy, m_hdr_valid, m_tvalid, m_tlast}), '0);
    chk("mid_rst_readies", HW'({s_hdr_ready, s_tready}), '0);
    chk("mid_rst_tdata", HW'(m_tdata), '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    s_tvalid = '0;
    @(negedge i_clk);
    chk("post_rst_edge1", HW'(o_grant), '0);
    @(negedge i_clk);
    chk("post_rst_edge2", HW'(o_grant), HW'(4'b0001));
    chk("post_rst_hdr", m_hdr_data, hdr_pat(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
